// File: rtl/pc_source_reg.sv
// Registered PC with NSRC prioritised next-PC sources; redirects seen during stall are held until release.
// Define PC_SOURCE_ALIGN_CHECK_EN to force loaded PCs to word alignment and flag align_err.
module pc_source_reg #(
  parameter int                 WIDTH    = 32,
  parameter int                 NSRC     = 4,
  parameter int                 SELW     = 2,
  parameter logic [WIDTH-1:0]   RESET_PC = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]      pc,
  output logic [SELW-1:0]       pc_src,
  output logic                  redirect,
  output logic                  align_err
);

`ifdef PC_SOURCE_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
`endif

  logic [WIDTH-1:0] pc_r;
  logic [SELW-1:0]  pc_src_r;
  logic             redirect_r;
  logic             align_err_r;
  logic [NSRC-1:1]  pend_r;
  logic [WIDTH-1:0] pdat_r [NSRC-1:1];

  logic [SELW-1:0]  win_idx_s;
  logic [WIDTH-1:0] win_data_s;
  logic [WIDTH-1:0] load_data_s;
  logic             load_misalign_s;

  // Source 0 is implicit, so its request bit carries no information.
  logic             unused_req0_s;
  assign unused_req0_s = src_req[0];

  // Priority select: ascending scan so the highest-index candidate overwrites lower ones.
  always_comb begin
    win_idx_s  = {SELW{1'b0}};
    win_data_s = src_data[0 +: WIDTH];
    for (int i = 1; i < NSRC; i++) begin
      if (src_req[i]) begin
        win_idx_s  = SELW'(i);
        win_data_s = src_data[i*WIDTH +: WIDTH];
      end else if (pend_r[i]) begin
        win_idx_s  = SELW'(i);
        win_data_s = pdat_r[i];
      end else begin
        win_idx_s  = win_idx_s;
        win_data_s = win_data_s;
      end
    end
  end

  // Optional word-alignment of the value about to be loaded.
  always_comb begin
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    load_data_s     = {win_data_s[WIDTH-1:2], 2'b00};
    load_misalign_s = misaligned(win_data_s);
`else
    load_data_s     = win_data_s;
    load_misalign_s = 1'b0;
`endif
  end

  // PC register, status pulses and the stall-time pending latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      pc_src_r    <= {SELW{1'b0}};
      redirect_r  <= 1'b0;
      align_err_r <= 1'b0;
      pend_r      <= {(NSRC-1){1'b0}};
      for (int i = 1; i < NSRC; i++) begin
        pdat_r[i] <= {WIDTH{1'b0}};
      end
    end else if (stall) begin
      redirect_r  <= 1'b0;
      align_err_r <= 1'b0;
      for (int i = 1; i < NSRC; i++) begin
        if (src_req[i]) begin
          pend_r[i] <= 1'b1;
          pdat_r[i] <= src_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      pc_r        <= load_data_s;
      pc_src_r    <= win_idx_s;
      redirect_r  <= (win_idx_s != {SELW{1'b0}});
      align_err_r <= load_misalign_s;
      pend_r      <= {(NSRC-1){1'b0}};
    end
  end

  assign pc        = pc_r;
  assign pc_src    = pc_src_r;
  assign redirect  = redirect_r;
  assign align_err = align_err_r;

endmodule

// File: tb/tb_pc_source_reg.sv
// Directed vector bench for pc_source_reg (WIDTH=32, NSRC=4); expectations follow PC_SOURCE_ALIGN_CHECK_EN.
module tb_pc_source_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [3:0]   src_req;
  logic [127:0] src_data;
  logic [31:0]  pc;
  logic [1:0]   pc_src;
  logic         redirect;
  logic         align_err;

  int errors = 0;
  int checks = 0;

  pc_source_reg #(.WIDTH(32), .NSRC(4), .SELW(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .src_req(src_req), .src_data(src_data),
    .pc(pc), .pc_src(pc_src), .redirect(redirect), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic [3:0]  req;
    logic [31:0] d0, d1, d2, d3;
    logic [31:0] e_pc;
    logic [1:0]  e_src;
    logic        e_redir;
    logic        e_align;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic s, logic [3:0] q,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] a2, logic [31:0] a3,
                              logic [31:0] ep, logic [1:0] es, logic er, logic ea);
    vec_t v;
    v.name = n; v.rst = r; v.stall = s; v.req = q;
    v.d0 = a0; v.d1 = a1; v.d2 = a2; v.d3 = a3;
    v.e_pc = ep; v.e_src = es; v.e_redir = er; v.e_align = ea;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] q,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3);
    @(negedge clk);
    rst = r; stall = s; src_req = q;
    src_data = {a3, a2, a1, a0};
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string n, input logic [31:0] ep, input logic [1:0] es,
                           input logic er, input logic ea);
    check({n, ".pc"},        pc,               ep);
    check({n, ".pc_src"},    {30'd0, pc_src},  {30'd0, es});
    check({n, ".redirect"},  {31'd0, redirect}, {31'd0, er});
    check({n, ".align_err"}, {31'd0, align_err}, {31'd0, ea});
  endtask

  logic [31:0] al_pc1, al_pc2;
  logic        al_flag;

  initial begin
`ifdef PC_SOURCE_ALIGN_CHECK_EN
    al_pc1 = 32'h0000_1000; al_pc2 = 32'h0000_0020; al_flag = 1'b1;
`else
    al_pc1 = 32'h0000_1002; al_pc2 = 32'h0000_0023; al_flag = 1'b0;
`endif
    rst = 1'b1; stall = 1'b1; src_req = 4'b0000; src_data = 128'd0;

    // reset overrides stall and requests
    vecs.push_back(mk("rst_a",    1'b1, 1'b1, 4'b1110, 32'h50, 32'h111, 32'h222, 32'h333, 32'h0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("rst_b",    1'b1, 1'b1, 4'b1110, 32'h50, 32'h111, 32'h222, 32'h333, 32'h0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("post_rst", 1'b0, 1'b0, 4'b0000, 32'h4,  32'h111, 32'h222, 32'h333, 32'h4, 2'd0, 1'b0, 1'b0));
    // sequential flow
    vecs.push_back(mk("seq_8",    1'b0, 1'b0, 4'b0000, 32'h8,  32'h0, 32'h0, 32'h0, 32'h8, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("seq_c",    1'b0, 1'b0, 4'b0000, 32'hC,  32'h0, 32'h0, 32'h0, 32'hC, 2'd0, 1'b0, 1'b0));
    // priority among live requests, one-cycle redirect
    vecs.push_back(mk("prio",     1'b0, 1'b0, 4'b1010, 32'h10, 32'h100, 32'h0, 32'h8000_0180, 32'h8000_0180, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk("prio_nxt", 1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, 32'h0, 32'h0, 32'h10, 2'd0, 1'b0, 1'b0));
    // stall capture with overwrite
    vecs.push_back(mk("stl_c1",   1'b0, 1'b1, 4'b0100, 32'h14, 32'h0, 32'h200, 32'h0, 32'h10, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("stl_c2",   1'b0, 1'b1, 4'b0100, 32'h14, 32'h0, 32'h204, 32'h0, 32'h10, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("stl_c3",   1'b0, 1'b1, 4'b0000, 32'h14, 32'h0, 32'h0, 32'h0, 32'h10, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("unstall",  1'b0, 1'b0, 4'b0000, 32'h14, 32'h0, 32'h0, 32'h0, 32'h204, 2'd2, 1'b1, 1'b0));
    vecs.push_back(mk("unstl_nx", 1'b0, 1'b0, 4'b0000, 32'h18, 32'h0, 32'h0, 32'h0, 32'h18, 2'd0, 1'b0, 1'b0));
    // lower pending flushed by live higher request
    vecs.push_back(mk("fl_cap",   1'b0, 1'b1, 4'b0010, 32'h1C, 32'h300, 32'h0, 32'h0, 32'h18, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("fl_live",  1'b0, 1'b0, 4'b1000, 32'h1C, 32'h0, 32'h0, 32'h180, 32'h180, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk("fl_after", 1'b0, 1'b0, 4'b0000, 32'h1C, 32'h0, 32'h0, 32'h0, 32'h1C, 2'd0, 1'b0, 1'b0));
    // live beats pending on the same index
    vecs.push_back(mk("same_cap", 1'b0, 1'b1, 4'b0010, 32'h0, 32'h400, 32'h0, 32'h0, 32'h1C, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("same_liv", 1'b0, 1'b0, 4'b0010, 32'h0, 32'h500, 32'h0, 32'h0, 32'h500, 2'd1, 1'b1, 1'b0));
    // older higher pending beats lower live
    vecs.push_back(mk("hp_cap",   1'b0, 1'b1, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h600, 32'h500, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk("hp_win",   1'b0, 1'b0, 4'b0010, 32'h0, 32'h700, 32'h0, 32'h0, 32'h600, 2'd3, 1'b1, 1'b0));
    vecs.push_back(mk("hp_after", 1'b0, 1'b0, 4'b0000, 32'h28, 32'h0, 32'h0, 32'h0, 32'h28, 2'd0, 1'b0, 1'b0));
    // reset mid-operation discards pending
    vecs.push_back(mk("mr_cap",   1'b0, 1'b1, 4'b0100, 32'h0, 32'h0, 32'h800, 32'h0, 32'h28, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("mr_rst",   1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk("mr_after", 1'b0, 1'b0, 4'b0000, 32'h24, 32'h0, 32'h0, 32'h0, 32'h24, 2'd0, 1'b0, 1'b0));
    // alignment on a redirect and on source 0
    vecs.push_back(mk("al_redir", 1'b0, 1'b0, 4'b0100, 32'h0, 32'h0, 32'h1002, 32'h0, al_pc1, 2'd2, 1'b1, al_flag));
    vecs.push_back(mk("al_seq",   1'b0, 1'b0, 4'b0000, 32'h23, 32'h0, 32'h0, 32'h0, al_pc2, 2'd0, 1'b0, al_flag));
    vecs.push_back(mk("al_clear", 1'b0, 1'b0, 4'b0000, 32'h40, 32'h0, 32'h0, 32'h0, 32'h40, 2'd0, 1'b0, 1'b0));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].stall, vecs[k].req, vecs[k].d0, vecs[k].d1, vecs[k].d2, vecs[k].d3);
      check_all(vecs[k].name, vecs[k].e_pc, vecs[k].e_src, vecs[k].e_redir, vecs[k].e_align);
    end

    // Long stall: index 1 rewritten every cycle, pc held throughout, last data wins on release.
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 4'b0010, 32'h44, 32'h900 + 32'(c * 4), 32'h0, 32'h0);
      check_all("long_stall", 32'h40, 2'd0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 4'b0000, 32'h44, 32'h0, 32'h0, 32'h0);
    check_all("long_rel", 32'h910, 2'd1, 1'b1, 1'b0);
    // A stall right after a redirect drops the pulse while pc holds.
    drive(1'b0, 1'b1, 4'b0000, 32'h48, 32'h0, 32'h0, 32'h0);
    check_all("rel_stall", 32'h910, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 32'h48, 32'h0, 32'h0, 32'h0);
    check_all("rel_resume", 32'h48, 2'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
